// File: rtl/mux_sel_pkg.sv
// Shared constants and elaboration helpers for the registered channel selector.
package mux_sel_pkg;

  localparam logic MODE_ORDER = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Channel-index width must be able to address every channel.
  function automatic bit sel_width_ok(input int unsigned n, input int unsigned selw);
    return clog2(n) <= selw;
  endfunction

endpackage

// File: rtl/mux_sel_pipe_rr_pick.sv
// Combinational round-robin picker: first valid channel at or above the
// pointer, wrapping to the lowest valid channel below it.
module rr_pick #(
  parameter int unsigned N    = 7,
  parameter int unsigned SELW = 3
) (
  input  logic [N-1:0]    i_valid,
  input  logic [SELW-1:0] i_ptr,
  output logic [SELW-1:0] o_idx,
  output logic            o_hit
);

  logic            w_hi_hit;
  logic            w_lo_hit;
  logic [SELW-1:0] w_hi_idx;
  logic [SELW-1:0] w_lo_idx;

  // Two priority scans instead of a modular rotate: the upper scan wins,
  // the plain lowest-valid scan supplies the wrap-around case.
  always_comb begin
    w_hi_hit = 1'b0;
    w_hi_idx = '0;
    w_lo_hit = 1'b0;
    w_lo_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_valid[i] && !w_lo_hit) begin
        w_lo_hit = 1'b1;
        w_lo_idx = SELW'(i);
      end
      if (i_valid[i] && !w_hi_hit && (i >= 32'(i_ptr))) begin
        w_hi_hit = 1'b1;
        w_hi_idx = SELW'(i);
      end
    end
  end

  assign o_hit = w_lo_hit;
  assign o_idx = w_hi_hit ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/mux_sel_pipe.sv
// N-channel registered selector with valid/ready inputs, select-by-Order or
// round-robin arbitration, and a 2-entry output buffer.
module mux_sel_pipe
  import mux_sel_pkg::*;
#(
  parameter int unsigned N    = 7,
  parameter int unsigned W    = 32,
  parameter int unsigned SELW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RrMode,
  input  logic [SELW-1:0] Order,
  input  logic [N*W-1:0]  DataIn,
  input  logic [N-1:0]    InValid,
  output logic [N-1:0]    InReady,
  output logic [W-1:0]    DataOut,
  output logic [SELW-1:0] OutChan,
  output logic            OutValid,
  input  logic            OutReady,
  output logic            SelErr
);

  if (!sel_width_ok(N, SELW) || (N < 2) || (N > 16)) begin : g_param_err
    $error("mux_sel_pipe: need 2 <= N <= 16 and 2**SELW >= N");
  end

  logic [SELW-1:0] r_ptr;
  logic [1:0]      r_cnt;
  logic [W-1:0]    r_data0;
  logic [W-1:0]    r_data1;
  logic [SELW-1:0] r_chan0;
  logic [SELW-1:0] r_chan1;
  logic            r_selerr;

  logic [SELW-1:0] w_rr_idx;
  logic            w_rr_hit;
  logic [SELW-1:0] w_c;
  logic            w_hit;
  logic            w_order_ok;
  logic            w_c_valid;
  logic [W-1:0]    w_din;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic [SELW-1:0] w_ptr_next;

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .i_valid (InValid),
    .i_ptr   (r_ptr),
    .o_idx   (w_rr_idx),
    .o_hit   (w_rr_hit)
  );

  assign w_order_ok = 32'(Order) < N;

  always_comb begin
    if (RrMode == MODE_RR) begin
      w_c   = w_rr_idx;
      w_hit = w_rr_hit;
    end else begin
      w_c   = Order;
      w_hit = w_order_ok;
    end
  end

  // Loop-based channel mux keeps out-of-range Order values from indexing past N.
  always_comb begin
    w_c_valid = 1'b0;
    w_din     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(w_c) == i) begin
        w_c_valid = InValid[i];
        w_din     = DataIn[i*W +: W];
      end
    end
  end

  assign w_pop  = (r_cnt != 2'd0) && OutReady;
  assign w_full = (r_cnt == 2'd2) && !w_pop;
  assign w_push = rst_n && w_hit && w_c_valid && !w_full;

  always_comb begin
    InReady = '0;
    for (int unsigned i = 0; i < N; i++) begin
      InReady[i] = w_push && (32'(w_c) == i);
    end
  end

  assign w_ptr_next = (32'(w_c) == N - 1) ? '0 : w_c + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_data0  <= '0;
      r_data1  <= '0;
      r_chan0  <= '0;
      r_chan1  <= '0;
      r_ptr    <= '0;
      r_selerr <= 1'b0;
    end else begin
      r_selerr <= (RrMode == MODE_ORDER) && !w_order_ok;
      if (w_push && (RrMode == MODE_RR)) r_ptr <= w_ptr_next;
      // Entry 0 is always the head so DataOut/OutChan come straight from flops.
      case ({w_push, w_pop})
        2'b01: begin
          r_data0 <= r_data1;
          r_chan0 <= r_chan1;
          r_cnt   <= r_cnt - 2'd1;
        end
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_data0 <= w_din;
            r_chan0 <= w_c;
          end else begin
            r_data1 <= w_din;
            r_chan1 <= w_c;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_data0 <= w_din;
            r_chan0 <= w_c;
          end else begin
            r_data0 <= r_data1;
            r_chan0 <= r_chan1;
            r_data1 <= w_din;
            r_chan1 <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign DataOut  = r_data0;
  assign OutChan  = r_chan0;
  assign OutValid = (r_cnt != 2'd0);
  assign SelErr   = r_selerr;

endmodule
